uart_tx_fifo_engine: RTL and testbench
======================================

# uart_tx_fifo_engine

Parametrised buffered UART transmitter: a small synchronous FIFO in front of a bit-serial frame engine supporting 5–8 data bits, optional odd/even parity and 1 or 2 stop bits. It sits on the processor output-port path. Software pushes bytes with `ld` without waiting per character. `txrdy` reports FIFO space, and `tx` drives the serial pin directly.

## Interface
- `FIFO_DEPTH`, 8, number of buffered characters; must be a power of two, ≥2.
- `BAUD_W`, 20, width of the bit-time count value.
- `clk  in  1  system clock; all logic on rising edge`
- `reset  in  1  synchronous, active-high`
- `ld  in  1  one-cycle push strobe; writes out_port into the FIFO`
- `out_port  in  8  character data; only low dbits bits are sent`
- `baud_rate  in  BAUD_W  bit time minus one, in clocks`
- `dbits  in  2  data length: 0→5, 1→6, 2→7, 3→8 bits`
- `pen  in  1  parity enable`
- `ohel  in  1  parity sense: 1 = odd, 0 = even`
- `stop2  in  1  1 = two stop bits, 0 = one`
- `brk  in  1  break request; used only with the break feature compiled in`
- `tx  out  1  serial output, idle high`
- `txrdy  out  1  high when the FIFO can accept a push`
- `busy  out  1  high while a frame or break is in progress, or the FIFO is non-empty`
- `fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy`
- `ovr  out  1  sticky overrun flag`
- `ovr_clr  in  1  clears ovr`

## Operation
- Reset values:
  - `tx`=1, `txrdy`=1, `busy`=0, `fifo_cnt`=0, `ovr`=0.
  - FIFO empty, state IDLE, all counters 0.
- Push:
  - `ld`=1 with `fifo_cnt`<FIFO_DEPTH writes the entry.
  - `ld`=1 when full drops the data and sets `ovr`. This holds even if a pop occurs in the same cycle, because fullness uses registered `fifo_cnt`.
  - `ovr_clr` clears `ovr`; if `ovr_clr` and a new overrun coincide, set wins.
- Frame format, sent LSB first:
  - start bit 0;
  - N data bits, N = `dbits`+5;
  - parity bit P if `pen`: P = ^data[N-1:0] for even, P = ~^data[N-1:0] for odd;
  - 1 or 2 stop bits of 1.
  - Frame length = 1+N+`pen`+1+`stop2` bits, i.e. 7..12.
- Format capture: `dbits`, `pen`, `ohel`, `stop2` are captured when the character is popped. Changes mid-frame do not affect the current frame.
- State machine:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop, load the shift register and frame length, go to SEND.
  - SEND: the bit-time counter runs 0..`baud_rate`. At terminal count, shift right with 1 fill and increment the bit count. On the last bit's terminal count:
    - FIFO non-empty → pop and reload directly, with no idle bit between frames;
    - FIFO empty → go to IDLE.
  - BRK and BRK_MARK exist only with the break feature compiled in (see Configuration).
- Arithmetic: the bit-time counter is BAUD_W wide and the bit counter is 4 bits. `baud_rate`=0 gives one clock per bit, which must work. FIFO pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: `tx` returns to 1 on the next edge, the FIFO is flushed and `ovr` is cleared.

## Timing
- Latency: `ld` high in cycle n, FIFO empty, engine IDLE:
  - entry written at the end of cycle n;
  - pop at the end of cycle n+1;
  - `tx`=0 (start bit) from cycle n+2.
- Each bit lasts exactly `baud_rate`+1 clocks.
- Back-to-back frames: the next start bit begins the cycle after the last stop bit ends.
- `txrdy` and `fifo_cnt` are registered and update the cycle after a push or pop. A simultaneous push and pop leaves the count unchanged.
- `busy` falls in the same cycle that `tx` completes the final stop bit and the FIFO is empty.

## Configuration
- Macro: `UART_TX_BREAK_EN`.
- Defined:
  - `brk`=1 seen in IDLE, or at the end of a frame, enters BRK: `tx`=0 and FIFO pops are inhibited.
  - On `brk` falling, enter BRK_MARK: `tx`=1 for one full bit time.
  - Then return to IDLE and resume draining.
  - `brk` is never honoured mid-frame.
- Undefined: `brk` is ignored, states BRK and BRK_MARK are absent, and the port remains for interface stability.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, SEND, BRK, BRK_MARK);
  - dbits encoding constants;
  - a frame-length function of (dbits, pen, stop2).
- Sub-module `uart_tx_fifo`: parametrised synchronous FIFO with registered count, full/empty, and drop-on-full. Shared with the future receiver.

## Test plan
- Reset, then `baud_rate`=3, `dbits`=3, `pen`=0, `stop2`=0, push 0x55 → `tx` from cycle n+2: 0,1,0,1,0,1,0,1,0,1, each 4 clocks, then idle high; `busy` falls after 40 clocks.
- `dbits`=2, `pen`=1, `ohel`=1, push 0x03 → 7 data bits 1100000, parity 1; repeat with `ohel`=0 → parity 0.
- `stop2`=1, push 0xA5 twice back-to-back → two stop bits, then the second start bit with no gap; total 2×11 bit times.
- `FIFO_DEPTH`=8, push 10 bytes on consecutive cycles while idle → 9 accepted (one popped on the fly), 1 dropped; `ovr`=1 and `txrdy`=0 at full; `ovr_clr` clears the flag.
- Assert `reset` mid-data-bit with 3 entries queued → `tx`=1 the next cycle, `fifo_cnt`=0, no further frames.
- With `UART_TX_BREAK_EN` defined: assert `brk` mid-frame → the frame completes, then `tx`=0 until `brk` falls, one bit time of 1, then queued data resumes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, data-length
// encoding and frame-length helpers.
// The break states are only reachable when UART_TX_BREAK_EN is defined.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        BRK      = 2'd2,
        BRK_MARK = 2'd3
    } tx_state_t;

    // dbits encoding
    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam int unsigned FRAME_MAX = 12;

    // start + (5+dbits) data + parity + stop(s)
    function automatic logic [3:0] frame_len(input logic [1:0] dbits,
                                             input logic       pen,
                                             input logic       stop2);
        return 4'd7 + {2'b00, dbits} + {3'b000, pen} + {3'b000, stop2};
    endfunction

    // Ones in the positions of the bits actually transmitted
    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        return 8'hFF >> (DBITS_8 - dbits);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered occupancy count, full/empty flags,
// drop-on-full writes and a sticky overrun flag. DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     ovr,
    input  logic                     ovr_clr
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_q;
    logic          ovr_q;
    logic          push;
    logic          pop;

    // Count is a power of two when full, so its MSB alone flags fullness
    assign full    = cnt_q[AW];
    assign empty   = (cnt_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign cnt     = cnt_q;
    assign ovr     = ovr_q;

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and overrun flag (set wins over clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (wr_en && full)
                ovr_q <= 1'b1;
            else if (ovr_clr)
                ovr_q <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// Buffered UART transmitter: FIFO plus bit-serial frame engine
// (5-8 data bits, optional parity, 1 or 2 stop bits).
// Optional break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_fifo_engine
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BAUD_W     = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld,
    input  logic [7:0]                    out_port,
    input  logic [BAUD_W-1:0]             baud_rate,
    input  logic [1:0]                    dbits,
    input  logic                          pen,
    input  logic                          ohel,
    input  logic                          stop2,
    input  logic                          brk,
    output logic                          tx,
    output logic                          txrdy,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          ovr,
    input  logic                          ovr_clr
);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [3:0]        len_q, len_d;
    logic [11:0]       sh_q, sh_d;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_data;
    logic [11:0]       new_frame;
    logic [3:0]        new_len;
    logic              term, last;
    logic              brk_req;

`ifdef UART_TX_BREAK_EN
    assign brk_req = brk;
`else
    logic unused_brk;
    assign unused_brk = brk;
    assign brk_req    = 1'b0;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ld),
        .wr_data (out_port),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .cnt     (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ovr     (ovr),
        .ovr_clr (ovr_clr)
    );

    assign txrdy = !fifo_full;
    assign busy  = (state_q != IDLE) || !fifo_empty;
    assign term  = (baud_q == baud_rate);
    assign last  = (bit_q == len_q - 4'd1);

    // Assemble the LSB-first frame for the FIFO head using the current format
    always_comb begin
        logic [7:0] mask;
        logic [7:0] d;
        logic [3:0] n;
        logic       par;
        mask      = data_mask(dbits);
        d         = fifo_data & mask;
        n         = 4'd5 + {2'b00, dbits};
        par       = ohel ? ~(^d) : ^d;
        // unused data positions are filled with ones so stop bits fall out naturally
        new_frame = {3'b111, d | ~mask, 1'b0};
        if (pen)
            new_frame[n + 4'd1] = par;
        new_len   = frame_len(dbits, pen, stop2);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        len_d   = len_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (brk_req) begin
                    state_d = BRK;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = new_frame;
                    len_d   = new_len;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (term) begin
                    baud_d = '0;
                    if (last) begin
                        bit_d = '0;
                        if (brk_req) begin
                            state_d = BRK;
                        end else if (!fifo_empty) begin
                            pop   = 1'b1;
                            sh_d  = new_frame;
                            len_d = new_len;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sh_d  = {1'b1, sh_q[11:1]};
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                baud_d = '0;
                if (!brk)
                    state_d = BRK_MARK;
            end
            BRK_MARK: begin
                if (term) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Serial pin: frame bits while sending, space during break, mark otherwise
    always_comb begin
        tx = 1'b1;
        case (state_q)
            SEND:    tx = sh_q[0];
`ifdef UART_TX_BREAK_EN
            BRK:     tx = 1'b0;
`endif
            default: tx = 1'b1;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            sh_q    <= '1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Self-checking bench for uart_tx_fifo_engine: expected frames are queued as
// bytes are pushed; a monitor checks every clock of every bit on tx.
module tb_uart_tx_fifo_engine;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned BW    = 20;

    logic          clk = 1'b0;
    logic          reset, ld, pen, ohel, stop2, brk, ovr_clr;
    logic [7:0]    out_port;
    logic [BW-1:0] baud_rate;
    logic [1:0]    dbits;
    logic          tx, txrdy, busy, ovr;
    logic [3:0]    fifo_cnt;

    typedef struct {
        logic [11:0] bits;
        int          len;
        int          baud;
    } frame_t;

    frame_t sb[$];
    int     chk_cnt  = 0;
    int     pass_cnt = 0;
    bit     mon_abort = 1'b0;
    bit     mon_hold  = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_engine #(
        .FIFO_DEPTH (DEPTH),
        .BAUD_W     (BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld        (ld),
        .out_port  (out_port),
        .baud_rate (baud_rate),
        .dbits     (dbits),
        .pen       (pen),
        .ohel      (ohel),
        .stop2     (stop2),
        .brk       (brk),
        .tx        (tx),
        .txrdy     (txrdy),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt),
        .ovr       (ovr),
        .ovr_clr   (ovr_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Push one byte; if it should be accepted, queue its expected frame
    task automatic send(input logic [7:0] b, input logic [11:0] bits, input int len, input bit accepted);
        frame_t f;
        if (accepted) begin
            f.bits = bits;
            f.len  = len;
            f.baud = int'(baud_rate);
            sb.push_back(f);
        end
        out_port = b;
        ld       = 1'b1;
        @(negedge clk);
        ld       = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk_cnt++;
        $display("FAIL %s: busy still 1 after 3000 cycles, expected 0", name);
    endtask

    // Compare one full frame; first sample is the current negedge (start bit)
    task automatic run_frame();
        frame_t f;
        logic   exp_b;
        logic   bad_v;
        bit     bad;
        if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_frame: start bit with tx=%b, expected no frame", tx);
            for (int i = 0; i < 200 && tx === 1'b0; i++) @(negedge clk);
            return;
        end
        f = sb.pop_front();
        for (int b = 0; b < f.len; b++) begin
            exp_b = 1'(f.bits >> b);
            bad   = 1'b0;
            bad_v = exp_b;
            for (int c = 0; c <= f.baud; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (mon_abort) return;
                if (tx !== exp_b) begin
                    bad   = 1'b1;
                    bad_v = tx;
                end
            end
            chk_cnt++;
            if (!bad) pass_cnt++;
            else $display("FAIL frame_bit%0d (frame %03h): got %b, expected %b", b, f.bits, bad_v, exp_b);
        end
    endtask

    // Monitor: detect start bits and check frames against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_hold && !mon_abort && tx === 1'b0) run_frame();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int saw0;
        reset = 1'b1; ld = 1'b0; out_port = '0; baud_rate = 20'd3; dbits = 2'd3;
        pen = 1'b0; ohel = 1'b0; stop2 = 1'b0; brk = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx",    32'(tx),       32'd1);
        check("reset_txrdy", 32'(txrdy),    32'd1);
        check("reset_busy",  32'(busy),     32'd0);
        check("reset_cnt",   32'(fifo_cnt), 32'd0);
        check("reset_ovr",   32'(ovr),      32'd0);

        // 8N1, 0x55, 4 clocks per bit
        send(8'h55, 12'h2AA, 10, 1'b1);
        check("lat_cnt_n1", 32'(fifo_cnt), 32'd1);
        @(negedge clk);
        check("lat_cnt_n2", 32'(fifo_cnt), 32'd0);
        check("lat_start_n2", 32'(tx), 32'd0);
        repeat (39) @(negedge clk);
        check("busy_n41", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_n42", 32'(busy), 32'd0);
        check("idle_tx_n42", 32'(tx), 32'd1);

        // 7 data bits, odd then even parity; format change mid-frame ignored
        dbits = 2'd2; pen = 1'b1; ohel = 1'b1;
        send(8'h03, 12'h306, 10, 1'b1);
        wait_idle("odd_parity");
        ohel = 1'b0;
        send(8'h03, 12'h206, 10, 1'b1);
        repeat (3) @(negedge clk);
        ohel = 1'b1; dbits = 2'd0;
        wait_idle("even_parity");

        // Two stop bits, back-to-back frames: 22 bit times with no gap
        dbits = 2'd3; pen = 1'b0; ohel = 1'b0; stop2 = 1'b1;
        send(8'hA5, 12'h74A, 11, 1'b1);
        send(8'hA5, 12'h74A, 11, 1'b1);
        repeat (87) @(negedge clk);
        check("b2b_busy_end", 32'(busy), 32'd1);
        check("b2b_stop_end", 32'(tx),   32'd1);
        @(negedge clk);
        check("b2b_busy_after", 32'(busy), 32'd0);

        // Overrun: 10 consecutive pushes, baud_rate 0
        stop2 = 1'b0; baud_rate = '0;
        for (int i = 0; i < 10; i++)
            send(8'h10 + 8'(i), {3'b001, 8'h10 + 8'(i), 1'b0}, 10, i < 9);
        check("full_cnt",   32'(fifo_cnt), 32'd8);
        check("full_txrdy", 32'(txrdy),    32'd0);
        check("ovr_set",    32'(ovr),      32'd1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr", 32'(ovr), 32'd0);
        wait_idle("overrun_drain");
        repeat (3) @(negedge clk);

        // Reset mid data bit with entries queued
        baud_rate = 20'd3;
        send(8'h11, 12'h222, 10, 1'b1);
        send(8'h22, 12'h244, 10, 1'b1);
        send(8'h33, 12'h266, 10, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1; mon_abort = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_mid_tx",   32'(tx),       32'd1);
        check("rst_mid_cnt",  32'(fifo_cnt), 32'd0);
        check("rst_mid_busy", 32'(busy),     32'd0);
        reset = 1'b0;
        saw0 = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw0++;
        end
        check("rst_no_frames", 32'(saw0), 32'd0);
        mon_abort = 1'b0;

`ifdef UART_TX_BREAK_EN
        // Break requested mid-frame: frame completes, space, one mark bit, resume
        send(8'h55, 12'h2AA, 10, 1'b1);
        repeat (9) @(negedge clk);
        brk = 1'b1; mon_hold = 1'b1;
        send(8'h0F, 12'h21E, 10, 1'b1);
        repeat (40) @(negedge clk);
        check("brk_space", 32'(tx),       32'd0);
        check("brk_held",  32'(fifo_cnt), 32'd1);
        brk  = 1'b0;
        saw0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw0++;
        end
        check("brk_mark", 32'(saw0), 32'd0);
        mon_hold = 1'b0;
        wait_idle("brk_resume");
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
